// File: rtl/div_pkg.sv
// div_pkg: shared encodings for the multicycle divide controller.
//   div_op_e    - op select encodings (signed/unsigned, quotient/remainder)
//   div_state_e - controller states
//   is_signed_op / is_rem_op - decode helpers for the op select
package div_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  // Signed ops are the ones with the low op bit clear (DIV, REM).
  function automatic logic is_signed_op(input div_op_e op);
    return ~op[0];
  endfunction

  // Remainder ops are the ones with the high op bit set (REM, REMU).
  function automatic logic is_rem_op(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one radix-2 restoring-division iteration.
//   rem, quo     - current partial remainder and quotient/dividend shift register
//   divisor      - divisor magnitude
//   rem_next     - partial remainder after shift + trial subtract
//   quo_next     - quotient register shifted left with the new quotient bit in the LSB
module div_restoring_step #(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] rem,
  input  logic [BUS_WIDTH-1:0] quo,
  input  logic [BUS_WIDTH-1:0] divisor,
  output logic [BUS_WIDTH-1:0] rem_next,
  output logic [BUS_WIDTH-1:0] quo_next
);

  // The shifted remainder can reach 2*divisor-1, which needs one bit more than
  // BUS_WIDTH once the divisor's MSB is set (unsigned ops), so the trial is
  // evaluated one bit wider than that and its top bit is the borrow.
  logic [BUS_WIDTH:0]   shifted;
  logic [BUS_WIDTH+1:0] trial;
  logic                 borrow;

  assign shifted = {rem, quo[BUS_WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = trial[BUS_WIDTH+1];

  // Both candidates fit in BUS_WIDTH bits: on borrow shifted < divisor,
  // otherwise the difference is < divisor.
  assign rem_next = borrow ? shifted[BUS_WIDTH-1:0] : trial[BUS_WIDTH-1:0];
  assign quo_next = {quo[BUS_WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multicycle RISC-V M-extension divide controller for EX.
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - divide present in EX (level, held while stalled)
//   op        - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  - rs1, sampled on acceptance
//   divisor   - rs2, sampled on acceptance
//   flush     - pipeline flush, aborts any operation
//   div_stall - hold IF/ID/EX while high
//   done      - one-cycle pulse, result valid
//   result    - registered quotient or remainder
// Divide-by-zero and signed overflow skip the iteration loop and finish in one cycle.
module div_sequencer
  import div_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int DIV_OP_WIDTH = 2,
  parameter int CNT_WIDTH    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIV_OP_WIDTH-1:0] op,
  input  logic [BUS_WIDTH-1:0]    dividend,
  input  logic [BUS_WIDTH-1:0]    divisor,
  input  logic                    flush,
  output logic                    div_stall,
  output logic                    done,
  output logic [BUS_WIDTH-1:0]    result
);

  localparam logic [BUS_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [BUS_WIDTH-1:0] MIN_VAL  = {1'b1, {(BUS_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(BUS_WIDTH - 1);

  div_state_e             state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [BUS_WIDTH-1:0]   rem_q;
  logic [BUS_WIDTH-1:0]   quo_q;
  logic [BUS_WIDTH-1:0]   dvs_q;
  logic                   is_rem_q;
  logic                   quo_neg_q;
  logic                   rem_neg_q;

  // Request decode, only meaningful in IDLE.
  div_op_e                op_e;
  logic                   sgn;
  logic                   rem_op;
  logic                   dvd_neg;
  logic                   dvs_neg;
  logic [BUS_WIDTH-1:0]   dvd_mag;
  logic [BUS_WIDTH-1:0]   dvs_mag;
  logic                   div_zero;
  logic                   sgn_ovf;
  logic                   accept;

  assign op_e     = div_op_e'(op[1:0]);
  assign sgn      = is_signed_op(op_e);
  assign rem_op   = is_rem_op(op_e);
  assign dvd_neg  = sgn & dividend[BUS_WIDTH-1];
  assign dvs_neg  = sgn & divisor[BUS_WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = sgn & (dividend == MIN_VAL) & (divisor == ALL_ONES);
  assign accept   = start & ~flush;

  // Stall is combinational so it rises in the same cycle the divide shows up
  // in EX; gating with rst keeps it low for the whole reset assertion even
  // though start may still be high.
  always_comb begin
    // NOTE: default first so every path assigns div_stall and no latch is inferred.
    div_stall = 1'b0;
    unique case (state)
      S_IDLE:  div_stall = accept;
      S_CALC:  div_stall = 1'b1;
      default: div_stall = 1'b0;
    endcase
    if (!rst) div_stall = 1'b0;
  end

  logic [BUS_WIDTH-1:0] rem_nx;
  logic [BUS_WIDTH-1:0] quo_nx;

  div_restoring_step #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Sign fix-up on the final iteration's outputs, registered straight into result.
  logic [BUS_WIDTH-1:0] final_val;
  assign final_val = is_rem_q ? (rem_neg_q ? -rem_nx : rem_nx)
                              : (quo_neg_q ? -quo_nx : quo_nx);

  // NOTE: all state updates are non-blocking so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      // Abort from any state; result keeps its last loaded value.
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_rem_q  <= rem_op;
            quo_neg_q <= dvd_neg ^ dvs_neg;
            rem_neg_q <= dvd_neg;
            if (div_zero) begin
              // Remainder is the original dividend, sign untouched.
              result <= rem_op ? dividend : ALL_ONES;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (sgn_ovf) begin
              result <= rem_op ? '0 : MIN_VAL;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              rem_q <= '0;
              quo_q <= dvd_mag;
              dvs_q <= dvs_mag;
              cnt   <= CNT_LOAD;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= final_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          // start is still high for the departing instruction; do not retrigger.
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors for div_sequencer. The driver pushes the
// hand-computed result into a scoreboard queue; an independent monitor pops
// and compares whenever done is seen. The driver also checks stall/latency.
module tb_div_sequencer;
  import div_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         div_stall;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] last_res = '0;

  div_sequencer #(
    .BUS_WIDTH    (W),
    .DIV_OP_WIDTH (2),
    .CNT_WIDTH    (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .div_stall (div_stall),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check(name_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  // Issue one divide at posedge+1 (cycle 0), hold start until done, then
  // leave one idle cycle. lat is the cycle number in which done must appear;
  // the stall must be high in every cycle before that and low in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input string name);
    int cyc    = 0;
    int stalls = 0;
    bit seen   = 0;
    logic stall_at_done = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    op = o; dividend = a; divisor = b; start = 1'b1;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        stall_at_done = div_stall;
      end else begin
        if (div_stall) stalls++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end else begin
      check({name, "_latency"}, 64'(cyc), 64'(lat));
      check({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
      check({name, "_stall_in_done"}, 64'(stall_at_done), 64'd0);
      last_res = exp;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;

    // Reset state, including stall forced low with start asserted.
    #12;
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    start = 1'b1;
    #1;
    check("rst_stall_forced_low", 64'(div_stall), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Normal path: latency 65, special cases: latency 1.
    do_op(DIV_OP_DIV,  64'd20, 64'd3, 64'd6, 65, "div_20_3");
    do_op(DIV_OP_REM,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_m20_3");
    do_op(DIV_OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65, "divu_max_2");
    do_op(DIV_OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65, "divu_big_divisor");
    do_op(DIV_OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
          64'h7FFF_FFFF_FFFF_FFFE, 65, "remu_big_divisor");
    do_op(DIV_OP_REM,  64'd20, -64'sd3, 64'd2, 65, "rem_20_m3");
    do_op(DIV_OP_DIV,  -64'sd7, -64'sd2, 64'd3, 65, "div_m7_m2");
    do_op(DIV_OP_DIV,  64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by_zero");
    do_op(DIV_OP_REMU, 64'd7, 64'd0, 64'd7, 1, "remu_by_zero");
    do_op(DIV_OP_REM,  -64'sd5, 64'd0, -64'sd5, 1, "rem_neg_by_zero");
    do_op(DIV_OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_overflow");
    do_op(DIV_OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, "div_overflow");
    do_op(DIV_OP_DIV,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, "div_m20_3");

    // Flush in IDLE with start high blocks acceptance.
    op = DIV_OP_DIV; dividend = 64'd9; divisor = 64'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 64'(div_stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_accept", 64'(done), 64'd0);
    @(posedge clk); #1;

    // Flush in cycle 10 of DIV 100/7: no done pulse, result unchanged.
    op = DIV_OP_DIV; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_back_to_idle", 64'(div_stall), 64'd0);
    check("flush_result_kept", result, last_res);
    repeat (3) @(posedge clk);
    #1;
    do_op(DIV_OP_DIVU, 64'd9, 64'd2, 64'd4, 65, "divu_after_flush");

    // Reset asserted in cycle 20 of a divide.
    op = DIV_OP_DIV; dividend = 64'd50; divisor = 64'd5; start = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    #1 rst = 1'b0;
    #1;
    check("midrst_stall", 64'(div_stall), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", result, 64'd0);
    @(posedge clk); #1;
    check("midrst_stall_held", 64'(div_stall), 64'd0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(DIV_OP_REMU, 64'd17, 64'd5, 64'd2, 65, "remu_after_reset");

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
